muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the EX stage of the RV32IM pipeline. It takes the same operand pair and M-extension op code that the EX stage decodes for the ALU, runs a 32-iteration shift-add multiply or restoring divide, and returns a 32-bit result with a START/BUSY/DONE handshake. While BUSY is high, the pipeline holds the stage.

---
 rtl/muldiv_if.sv | 36 +++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and muldiv_unit.
//
// Handshake: a request is taken in any cycle where i_start=1 and o_busy=0.
// o_busy stays high from the cycle after acceptance through the completion
// cycle. o_done pulses for exactly one cycle, and o_result is valid in that
// cycle. i_kill aborts whatever is in flight and produces no o_done.
//
// Signals (names as seen from the unit):
//   i_start  request strobe
//   i_op     funct3 code (MUL..REMU)
//   i_data1  rs1 operand (multiplicand / dividend)
//   i_data2  rs2 operand (multiplier / divisor)
//   i_kill   pipeline flush
//   o_busy   unit is not idle
//   o_done   one-cycle completion pulse
//   o_result 32-bit result, held until the next o_done
interface muldiv_if;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_data1;
  logic [31:0] i_data2;
  logic        i_kill;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  modport master (
    output i_start, i_op, i_data1, i_data2, i_kill,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_data1, i_data2, i_kill,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// A 32-step unsigned shift-add multiply or restoring divide runs on operand
// magnitudes. The sign is reapplied when the result is formed in the FIN
// cycle. Divide-by-zero and signed overflow skip the iterations and go
// straight to FIN.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   bus          muldiv_if.slave (start/op/data1/data2/kill in; busy/done/result out)
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC, 2 FIN)
module muldiv_unit (
  input  logic          i_clk,
  input  logic          i_reset,
  muldiv_if.slave       bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t      r_state, w_next;

  logic [2:0]  r_op;
  logic [31:0] r_a;          // multiplicand magnitude (multiply only)
  logic [31:0] r_b;          // divisor magnitude (divide only)
  logic        r_neg;
  logic [4:0]  r_cnt;
  logic        r_special;
  logic [31:0] r_special_val;
  logic [63:0] r_prod;       // {partial product, remaining multiplier bits}
  logic [31:0] r_rem;
  logic [31:0] r_quo;        // dividend shifts out of the top, quotient shifts in
  logic [31:0] r_result;

  // ---------------- accept-time operand conditioning ----------------
  logic        w_sa_op, w_sb_op, w_sign_a, w_sign_b, w_neg;
  logic [31:0] w_mag_a, w_mag_b;
  logic        w_div0, w_ovf, w_special;
  logic [31:0] w_special_val;
  logic        w_accept;

  always_comb begin
    w_sa_op  = (bus.i_op == 3'b001) || (bus.i_op == 3'b010) ||
               (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
    w_sb_op  = (bus.i_op == 3'b001) || (bus.i_op == 3'b100) ||
               (bus.i_op == 3'b110);
    w_sign_a = w_sa_op && bus.i_data1[31];
    w_sign_b = w_sb_op && bus.i_data2[31];
    w_mag_a  = w_sign_a ? (~bus.i_data1 + 32'd1) : bus.i_data1;
    w_mag_b  = w_sign_b ? (~bus.i_data2 + 32'd1) : bus.i_data2;
    // The remainder takes the dividend's sign. Everything else uses the XOR.
    w_neg    = (bus.i_op == 3'b110) ? w_sign_a : (w_sign_a ^ w_sign_b);
    w_div0   = bus.i_op[2] && (bus.i_data2 == 32'd0);
    w_ovf    = ((bus.i_op == 3'b100) || (bus.i_op == 3'b110)) &&
               (bus.i_data1 == 32'h8000_0000) && (bus.i_data2 == 32'hFFFF_FFFF);
    w_special = w_div0 || w_ovf;
    if (w_div0) w_special_val = bus.i_op[1] ? bus.i_data1 : 32'hFFFF_FFFF;
    else        w_special_val = bus.i_op[1] ? 32'd0 : 32'h8000_0000;
    w_accept = (r_state == ST_IDLE) && bus.i_start && !bus.i_kill;
  end

  // ---------------- one iteration of each datapath ----------------
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_a} : 33'd0);
    w_shift = {r_rem, r_quo[31]};
    // The partial remainder is always below the divisor, so bit 32 of the
    // difference is set exactly when the trial subtraction borrows.
    w_diff  = w_shift - {1'b0, r_b};
  end

  // ---------------- final result formation ----------------
  logic [63:0] w_prod_s;
  logic [31:0] w_quo_s, w_rem_s, w_final;

  always_comb begin
    w_prod_s = r_neg ? (~r_prod + 64'd1) : r_prod;
    w_quo_s  = r_neg ? (~r_quo + 32'd1) : r_quo;
    w_rem_s  = r_neg ? (~r_rem + 32'd1) : r_rem;
    if (r_special)       w_final = r_special_val;
    else if (r_op[2])    w_final = r_op[1] ? w_rem_s : w_quo_s;
    else                 w_final = (r_op[1:0] == 2'b00) ? w_prod_s[31:0] : w_prod_s[63:32];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.i_start) w_next = w_special ? ST_FIN : ST_CALC;
      ST_CALC: if (r_cnt == 5'd31) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (bus.i_kill) w_next = ST_IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op          <= 3'd0;
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_neg         <= 1'b0;
      r_cnt         <= 5'd0;
      r_special     <= 1'b0;
      r_special_val <= 32'd0;
      r_prod        <= 64'd0;
      r_rem         <= 32'd0;
      r_quo         <= 32'd0;
      r_result      <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op          <= bus.i_op;
        r_a           <= w_mag_a;
        r_b           <= w_mag_b;
        r_neg         <= w_neg;
        r_cnt         <= 5'd0;
        r_special     <= w_special;
        r_special_val <= w_special_val;
        r_prod        <= {32'd0, w_mag_b};
        r_rem         <= 32'd0;
        r_quo         <= w_mag_a;
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt + 5'd1;
        if (!r_op[2]) begin
          r_prod <= {w_sum, r_prod[31:1]};
        end else if (!w_diff[32]) begin
          r_rem <= w_diff[31:0];
          r_quo <= {r_quo[30:0], 1'b1};
        end else begin
          r_rem <= w_shift[31:0];
          r_quo <= {r_quo[30:0], 1'b0};
        end
      end
      if ((r_state == ST_FIN) && !bus.i_kill) r_result <= w_final;
    end
  end

  // In FIN the fresh result is driven through so that it is visible together
  // with DONE. A KILL in that cycle hides both, and the held value stays put.
  assign bus.o_busy   = (r_state != ST_IDLE);
  assign bus.o_done   = (r_state == ST_FIN) && !bus.i_kill;
  assign bus.o_result = bus.o_done ? w_final : r_result;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;
  int         checks;
  int         errors;
  logic [31:0] last_res;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  muldiv_if bus ();

  muldiv_unit dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cycle=%0d result=%h", cyc, bus.o_result);
      end else begin
        logic [31:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if (bus.o_result !== e || cyc != ec) begin
          errors++;
          $display("FAIL result got=%h@cycle%0d exp=%h@cycle%0d", bus.o_result, cyc, e, ec);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // Called at a negedge; waits (bounded) for the unit to go idle.
  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (bus.o_busy && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (bus.o_busy) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input int lat);
    int  c0;
    logic ok;
    @(negedge clk);
    wait_idle(name);
    c0 = cyc;
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_data1 = a;
    bus.i_data2 = b;
    exp_q.push_back(expv);
    exp_cyc_q.push_back(c0 + lat);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_data1 = $urandom;
    bus.i_data2 = $urandom;
    ok = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (bus.o_busy !== (k <= lat)) ok = 1'b0;
    end
    chk({name, "_busy_window"}, {31'd0, ok}, 32'd1);
    last_res = expv;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = 3'd0;
    bus.i_data1 = 32'd0;
    bus.i_data2 = 32'd0;
    bus.i_kill  = 1'b0;
    checks = 0;
    errors = 0;
    last_res = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",   {31'd0, bus.o_busy}, 32'd0);
    chk("reset_done",   {31'd0, bus.o_done}, 32'd0);
    chk("reset_result", bus.o_result, 32'd0);

    // multiply
    run_op("mulhu_ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul_ff",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_op("mulh_m2x3", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
    run_op("mul_m2x3",  3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 33);
    // -2 * 4294967295 = 0xFFFFFFFE_00000002
    run_op("mulhsu",    3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhu_2p32",3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33);
    run_op("mul_shift", 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
    // divide
    run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    run_op("div_7_m2",  3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",  3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("divu_100_7",3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7",3'b111, 32'd100, 32'd7, 32'd2, 33);
    // special cases
    run_op("divu_div0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_div0",  3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("remu_div0", 3'b111, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // START held through cycles 0..34: two ops, second samples cycle-34 operands
    @(negedge clk);
    wait_idle("held");
    c0 = cyc;
    bus.i_start = 1'b1;
    bus.i_op    = 3'b000;
    bus.i_data1 = 32'd3;
    bus.i_data2 = 32'd5;
    exp_q.push_back(32'd15);  exp_cyc_q.push_back(c0 + 33);
    exp_q.push_back(32'd14);  exp_cyc_q.push_back(c0 + 67);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk);
      #1;
      if (k < 34) begin
        bus.i_op    = 3'b000;
        bus.i_data1 = $urandom;
        bus.i_data2 = $urandom;
      end else if (k == 34) begin
        bus.i_op    = 3'b101;
        bus.i_data1 = 32'd100;
        bus.i_data2 = 32'd7;
      end else begin
        bus.i_start = 1'b0;
      end
    end
    @(negedge clk);
    wait_idle("held2");
    last_res = 32'd14;

    // KILL in cycle 10, restart in cycle 11 completes at cycle 44
    @(negedge clk);
    c0 = cyc;
    bus.i_start = 1'b1;
    bus.i_op    = 3'b011;
    bus.i_data1 = 32'hFFFF_FFFF;
    bus.i_data2 = 32'hFFFF_FFFF;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      if (k == 10) begin
        bus.i_kill  = 1'b1;
        bus.i_start = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.i_kill  = 1'b0;
    bus.i_start = 1'b1;
    bus.i_op    = 3'b101;
    bus.i_data1 = 32'd100;
    bus.i_data2 = 32'd7;
    exp_q.push_back(32'd14);
    exp_cyc_q.push_back(c0 + 44);
    @(negedge clk);
    chk("kill_busy",   {31'd0, bus.o_busy}, 32'd0);
    chk("kill_result", bus.o_result, last_res);
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    @(negedge clk);
    wait_idle("kill_restart");
    last_res = 32'd14;

    // KILL in the FIN cycle of a special-case op
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = 3'b101;
    bus.i_data1 = 32'd5;
    bus.i_data2 = 32'd0;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_kill  = 1'b1;
    @(negedge clk);
    chk("killfin_done",   {31'd0, bus.o_done}, 32'd0);
    chk("killfin_result", bus.o_result, last_res);
    @(posedge clk);
    #1 bus.i_kill = 1'b0;
    @(negedge clk);
    chk("killfin_busy",   {31'd0, bus.o_busy}, 32'd0);
    chk("killfin_held",   bus.o_result, last_res);

    // RESET in cycle 20 of an op
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = 3'b000;
    bus.i_data1 = 32'h1234_5678;
    bus.i_data2 = 32'd3;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      if (k == 20) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy",   {31'd0, bus.o_busy}, 32'd0);
    chk("rst_mid_done",   {31'd0, bus.o_done}, 32'd0);
    chk("rst_mid_result", bus.o_result, 32'd0);
    repeat (40) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
